// File: rtl/vga_rx_monitor.sv
// vga_rx_monitor
//   Receive-side decoder for a 640x480 VGA stream. Oversamples the pixel
//   clock and syncs on clk, recovers pixel coordinates and a pixel-valid
//   stream, measures line/frame timing and locks after a run of clean frames.
//
// State table:
//   ST_SEARCH | waiting for the first VS falling edge; no pixels emitted
//   ST_SYNC   | counting consecutive error-free frames toward lock
//   ST_LOCKED | timing lock held; any timing error drops back to ST_SYNC
//
// Ports:
//   clk, reset                 system clock, synchronous active-high reset
//   VGA_CLK                    pixel clock, sampled as data
//   VGA_HS, VGA_VS             syncs, active low
//   VGA_BLANK_n                high during active video
//   VGA_R/G/B                  pixel colour
//   pix_valid/pix_x/pix_y/pix_rgb   recovered pixel stream
//   frame_start                pulse per VS falling edge
//   locked                     timing lock achieved
//   err_hlen/err_vlen/err_hact error pulses
//   err_count                  saturating sum of error pulses
//   line_len                   last measured line length in pixel strobes
module vga_rx_monitor #(
  parameter int HACTIVE     = 640,
  parameter int VACTIVE     = 480,
  parameter int HTOTAL_PIX  = 800,
  parameter int VTOTAL      = 525,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        VGA_CLK,
  input  logic        VGA_HS,
  input  logic        VGA_VS,
  input  logic        VGA_BLANK_n,
  input  logic [7:0]  VGA_R,
  input  logic [7:0]  VGA_G,
  input  logic [7:0]  VGA_B,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [23:0] pix_rgb,
  output logic        frame_start,
  output logic        locked,
  output logic        err_hlen,
  output logic        err_vlen,
  output logic        err_hact,
  output logic [15:0] err_count,
  output logic [10:0] line_len
);

  localparam logic [9:0]  X_LAST  = 10'(HACTIVE - 1);
  localparam logic [9:0]  Y_LAST  = 10'(VACTIVE - 1);
  localparam logic [10:0] H_TOTAL = 11'(HTOTAL_PIX);
  localparam logic [10:0] V_TOTAL = 11'(VTOTAL);
  localparam logic [7:0]  LOCK_N  = 8'(LOCK_FRAMES);
  localparam logic [10:0] CNT_MAX = 11'h7FF;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_SYNC   = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t state, state_n;
  logic [7:0] good, good_n, good_inc;

  // Input stage. Only VGA_CLK is needed from the second stage.
  logic        s1_clk, s1_hs, s1_vs, s1_bl;
  logic [23:0] s1_rgb;
  logic        s2_clk;

  logic        prev_hs, prev_vs, prev_bl;
  logic [9:0]  x_cnt, y_cnt;
  logic        x_full, hact_seen;
  logic [10:0] hlen, vlen;
  logic        frame_err;

  logic        stb, hs_fall, vs_fall, bl_fall, searching, pix_now;
  logic [9:0]  x_base, y_base;
  logic        x_full_base, hact_seen_base;
  logic        hlen_err, vlen_err, hact_err, err_any, frame_ok;
  logic [1:0]  err_sum;
  logic [16:0] err_total;

  assign stb       = s1_clk & ~s2_clk;
  assign hs_fall   = stb & ~s1_hs & prev_hs;
  assign vs_fall   = stb & ~s1_vs & prev_vs;
  assign bl_fall   = stb & ~s1_bl & prev_bl;
  assign searching = (state == ST_SEARCH);
  assign pix_now   = stb & s1_bl & ~searching;

  // An HS fall restarts the line on the same strobe it is seen.
  assign x_base         = hs_fall ? 10'd0 : x_cnt;
  assign x_full_base    = x_full & ~hs_fall;
  assign hact_seen_base = hact_seen & ~hs_fall;
  assign y_base         = vs_fall ? 10'd0 : y_cnt;

  // x_full marks that column HACTIVE-1 was already emitted on this line,
  // so any further pixel overruns the active width.
  assign hlen_err = hs_fall & (hlen != H_TOTAL) & ~searching;
  assign vlen_err = vs_fall & (vlen != V_TOTAL) & ~searching;
  assign hact_err = pix_now & x_full_base & ~hact_seen_base;
  assign err_any  = hlen_err | vlen_err | hact_err;
  assign frame_ok = ~frame_err & ~err_any;

  assign err_sum   = {1'b0, hlen_err} + {1'b0, vlen_err} + {1'b0, hact_err};
  assign err_total = {1'b0, err_count} + {15'd0, err_sum};
  assign good_inc  = good + 8'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_SEARCH;
      good  <= '0;
    end else begin
      state <= state_n;
      good  <= good_n;
    end
  end

  always_comb begin
    state_n = state;
    good_n  = good;
    case (state)
      ST_SEARCH: begin
        if (vs_fall) begin
          state_n = ST_SYNC;
          good_n  = '0;
        end
      end
      ST_SYNC: begin
        if (vs_fall) begin
          if (frame_ok) begin
            good_n = good_inc;
            if (good_inc >= LOCK_N) state_n = ST_LOCKED;
          end else begin
            good_n = '0;
          end
        end
      end
      ST_LOCKED: begin
        if (err_any) begin
          state_n = ST_SYNC;
          good_n  = '0;
        end
      end
      default: begin
        state_n = ST_SEARCH;
        good_n  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_clk      <= 1'b0;
      s1_hs       <= 1'b0;
      s1_vs       <= 1'b0;
      s1_bl       <= 1'b0;
      s1_rgb      <= '0;
      s2_clk      <= 1'b0;
      prev_hs     <= 1'b0;
      prev_vs     <= 1'b0;
      prev_bl     <= 1'b0;
      x_cnt       <= '0;
      y_cnt       <= '0;
      x_full      <= 1'b0;
      hact_seen   <= 1'b0;
      hlen        <= '0;
      vlen        <= '0;
      frame_err   <= 1'b0;
      pix_valid   <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_rgb     <= '0;
      frame_start <= 1'b0;
      locked      <= 1'b0;
      err_hlen    <= 1'b0;
      err_vlen    <= 1'b0;
      err_hact    <= 1'b0;
      err_count   <= '0;
      line_len    <= '0;
    end else begin
      s1_clk <= VGA_CLK;
      s1_hs  <= VGA_HS;
      s1_vs  <= VGA_VS;
      s1_bl  <= VGA_BLANK_n;
      s1_rgb <= {VGA_R, VGA_G, VGA_B};
      s2_clk <= s1_clk;

      if (stb) begin
        prev_hs <= s1_hs;
        prev_vs <= s1_vs;
        prev_bl <= s1_bl;
      end

      pix_valid   <= pix_now;
      frame_start <= vs_fall;
      err_hlen    <= hlen_err;
      err_vlen    <= vlen_err;
      err_hact    <= hact_err;
      locked      <= (state == ST_LOCKED);
      err_count   <= err_total[16] ? 16'hFFFF : err_total[15:0];

      if (pix_now) begin
        pix_x   <= x_base;
        pix_y   <= y_base;
        pix_rgb <= s1_rgb;
        x_cnt   <= (x_base == X_LAST) ? x_base : x_base + 10'd1;
      end else if (hs_fall) begin
        x_cnt <= '0;
      end
      x_full    <= x_full_base | (pix_now & (x_base == X_LAST));
      hact_seen <= hact_seen_base | hact_err;

      if (vs_fall) begin
        y_cnt <= '0;
      end else if (bl_fall && (y_cnt != Y_LAST)) begin
        y_cnt <= y_cnt + 10'd1;
      end

      // hlen includes the strobe carrying the HS fall, hence restart at 1.
      if (hs_fall) begin
        line_len <= hlen;
        hlen     <= 11'd1;
      end else if (stb && (hlen != CNT_MAX)) begin
        hlen <= hlen + 11'd1;
      end

      // A coincident HS fall is line 0 of the new frame.
      if (vs_fall) begin
        vlen <= hs_fall ? 11'd1 : 11'd0;
      end else if (hs_fall && (vlen != CNT_MAX)) begin
        vlen <= vlen + 11'd1;
      end

      if (vs_fall) begin
        frame_err <= 1'b0;
      end else if (err_any) begin
        frame_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vga_rx_monitor.sv
// tb_vga_rx_monitor
//   Drives a scaled-down VGA raster (8x4 active, 16x8 total) into
//   vga_rx_monitor and scores the recovered pixel stream and timing flags.
module tb_vga_rx_monitor;

  localparam int HACT  = 8;
  localparam int VACT  = 4;
  localparam int HTOT  = 16;
  localparam int VTOT  = 8;
  localparam int LOCKF = 2;
  localparam int HS_W  = 2;
  localparam int ACT0  = 4;
  localparam int ROW0  = 3;

  logic        clk, reset;
  logic        VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_n;
  logic [7:0]  VGA_R, VGA_G, VGA_B;
  logic        pix_valid, frame_start, locked, err_hlen, err_vlen, err_hact;
  logic [9:0]  pix_x, pix_y;
  logic [23:0] pix_rgb;
  logic [15:0] err_count;
  logic [10:0] line_len;

  vga_rx_monitor #(
    .HACTIVE(HACT), .VACTIVE(VACT), .HTOTAL_PIX(HTOT), .VTOTAL(VTOT),
    .LOCK_FRAMES(LOCKF)
  ) dut (
    .clk(clk), .reset(reset),
    .VGA_CLK(VGA_CLK), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
    .VGA_BLANK_n(VGA_BLANK_n), .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
    .frame_start(frame_start), .locked(locked),
    .err_hlen(err_hlen), .err_vlen(err_vlen), .err_hact(err_hact),
    .err_count(err_count), .line_len(line_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [23:0] rgb;
  } pix_t;

  typedef struct {
    int   frames;
    int   short_f;
    int   extra_f;
    int   wide_f;
    int   pv;
    int   eh;
    int   ev;
    int   ea;
    int   ec;
    logic lk;
  } scen_t;

  pix_t exp_q[$];
  pix_t mon_e;
  int   total = 0;
  int   bad   = 0;
  int   n_pv = 0, n_fs = 0, n_eh = 0, n_ev = 0, n_ea = 0;
  int   hlen_at_err = 0;
  int   lock_fs = -1;
  logic locked_d = 1'b0;
  logic err_pend = 1'b0;
  bit   expect_active = 1'b0;
  logic drv_prev_vs = 1'b1;

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (pix_valid) begin
      n_pv++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL pix_unexpected: got x=%0d y=%0d want no pixel", pix_x, pix_y);
      end else begin
        mon_e = exp_q.pop_front();
        chk("pix", {pix_x, pix_y, pix_rgb}, {mon_e.x, mon_e.y, mon_e.rgb});
      end
    end
    if (frame_start) n_fs++;
    if (err_hlen) begin
      n_eh++;
      hlen_at_err = int'(line_len);
    end
    if (err_vlen) n_ev++;
    if (err_hact) n_ea++;
    if (err_pend) chk("locked_after_err", locked, 1'b0);
    err_pend = err_hlen | err_vlen | err_hact;
    if (locked && !locked_d && lock_fs < 0) lock_fs = n_fs;
    locked_d = locked;
  end

  task automatic drive_pix(input logic hs, input logic vs, input logic bl,
                           input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    @(negedge clk);
    VGA_CLK = 1'b0;
    VGA_HS = hs;
    VGA_VS = vs;
    VGA_BLANK_n = bl;
    VGA_R = r;
    VGA_G = g;
    VGA_B = b;
    if (drv_prev_vs && !vs) expect_active = 1'b1;
    drv_prev_vs = vs;
    @(negedge clk);
    VGA_CLK = 1'b1;
  endtask

  task automatic std_line(input int l, input int len, input int nact);
    logic hs, vs, bl;
    logic [7:0] r, g, b;
    int row, col;
    pix_t e;
    vs  = (l < 2) ? 1'b0 : 1'b1;
    row = (l >= ROW0 && l < ROW0 + VACT) ? l - ROW0 : -1;
    for (int p = 0; p < len; p++) begin
      hs  = (p >= HS_W);
      bl  = (row >= 0) && (p >= ACT0) && (p < ACT0 + nact);
      col = p - ACT0;
      r = bl ? 8'(col) : 8'h00;
      g = bl ? 8'(row) : 8'h00;
      b = bl ? 8'h5A : 8'h00;
      drive_pix(hs, vs, bl, r, g, b);
      if (bl && expect_active) begin
        e.x   = 10'((col > HACT - 1) ? HACT - 1 : col);
        e.y   = 10'(row);
        e.rgb = {r, g, b};
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic drive_frame(input int nlines, input int short_l, input int wide_l);
    for (int l = 0; l < nlines; l++)
      std_line(l, (l == short_l) ? HTOT - 4 : HTOT, (l == wide_l) ? HACT + 2 : HACT);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    scen_t scen[4];
    int pv0, eh0, ev0, ea0, fs0;

    scen[0] = '{4, -1, -1, -1, 128, 0, 0, 0, 0, 1'b1};
    scen[1] = '{4,  0, -1, -1, 128, 1, 0, 0, 1, 1'b1};
    scen[2] = '{4, -1,  0, -1, 128, 0, 1, 0, 2, 1'b1};
    scen[3] = '{4, -1, -1,  0, 130, 0, 0, 1, 3, 1'b1};

    reset = 1'b1;
    VGA_CLK = 1'b0; VGA_HS = 1'b1; VGA_VS = 1'b1; VGA_BLANK_n = 1'b0;
    VGA_R = 8'h00; VGA_G = 8'h00; VGA_B = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_outputs",
        {pix_valid, pix_x, pix_y, pix_rgb, frame_start, locked, err_hlen, err_vlen,
         err_hact, err_count, line_len}, '0);
    reset = 1'b0;
    repeat (6) drive_pix(1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);

    for (int s = 0; s < 4; s++) begin
      pv0 = n_pv; eh0 = n_eh; ev0 = n_ev; ea0 = n_ea;
      for (int f = 0; f < scen[s].frames; f++)
        drive_frame((f == scen[s].extra_f) ? VTOT + 1 : VTOT,
                    (f == scen[s].short_f) ? 2 : -1,
                    (f == scen[s].wide_f) ? ROW0 : -1);
      repeat (4) @(negedge clk);
      chk($sformatf("s%0d_pix_count", s), n_pv - pv0, scen[s].pv);
      chk($sformatf("s%0d_err_hlen", s), n_eh - eh0, scen[s].eh);
      chk($sformatf("s%0d_err_vlen", s), n_ev - ev0, scen[s].ev);
      chk($sformatf("s%0d_err_hact", s), n_ea - ea0, scen[s].ea);
      chk($sformatf("s%0d_err_count", s), err_count, scen[s].ec);
      chk($sformatf("s%0d_locked", s), locked, scen[s].lk);
      chk($sformatf("s%0d_line_len", s), line_len, HTOT);
      if (scen[s].eh > 0) chk($sformatf("s%0d_short_len", s), hlen_at_err, HTOT - 4);
      if (s == 0) chk("lock_at_vs_fall", lock_fs, 3);
    end

    // Pixel clock stalls between two lines while locked: everything holds.
    pv0 = n_pv; fs0 = n_fs;
    for (int l = 0; l < 4; l++) std_line(l, HTOT, HACT);
    repeat (4) @(negedge clk);
    eh0 = n_pv; ea0 = n_fs;
    repeat (60) begin
      @(negedge clk);
      VGA_HS = 1'($urandom); VGA_VS = 1'($urandom); VGA_BLANK_n = 1'($urandom);
      VGA_R = 8'($urandom); VGA_G = 8'($urandom); VGA_B = 8'($urandom);
    end
    chk("stuck_no_events", {32'(n_pv - eh0), 32'(n_fs - ea0)}, 0);
    chk("stuck_hold", {pix_x, pix_y, pix_rgb, line_len, err_count, locked},
        {10'd7, 10'd0, 24'h07005A, 11'(HTOT), 16'd3, 1'b1});
    for (int l = 4; l < VTOT; l++) std_line(l, HTOT, HACT);
    repeat (4) @(negedge clk);
    chk("stuck_frame_pix", n_pv - pv0, HACT * VACT);
    chk("stuck_frame_starts", n_fs - fs0, 1);
    chk("stuck_err_count", err_count, 3);

    // Reset in the middle of a locked frame.
    for (int l = 0; l < 5; l++) std_line(l, HTOT, HACT);
    chk("locked_before_reset", locked, 1'b1);
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_mid_outputs",
        {pix_valid, pix_x, pix_y, pix_rgb, frame_start, locked, err_hlen, err_vlen,
         err_hact, err_count, line_len}, '0);
    @(negedge clk) reset = 1'b0;
    exp_q.delete();
    expect_active = 1'b0;
    pv0 = n_pv; fs0 = n_fs; eh0 = n_eh; ev0 = n_ev; ea0 = n_ea;
    for (int l = 5; l < VTOT; l++) std_line(l, HTOT, HACT);
    repeat (4) @(negedge clk);
    chk("no_pix_before_vs", n_pv - pv0, 0);
    drive_frame(VTOT, -1, -1);
    repeat (4) @(negedge clk);
    chk("post_reset_pix", n_pv - pv0, HACT * VACT);
    chk("post_reset_fs", n_fs - fs0, 1);
    chk("post_reset_errs", {32'(n_eh - eh0), 32'(n_ev - ev0), 32'(n_ea - ea0)}, 0);
    chk("post_reset_err_count", err_count, 0);
    chk("post_reset_locked", locked, 1'b0);
    chk("queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
